btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_if.sv | 23 ++
 rtl/btn_conditioner.sv | 138 +++++++++++++
 tb/tb_btn_conditioner.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Raw button/switch inputs and conditioned outputs of btn_conditioner.
interface btn_conditioner_if;
    logic       BTN_SOUTH;
    logic       BTN_WEST;
    logic       BTN_EAST;
    logic [3:0] SW;
    logic [2:0] BTN_LVL;
    logic [2:0] BTN_PRESS;
    logic [2:0] BTN_REL;
    logic [2:0] BTN_STEP;
    logic [3:0] SW_LVL;
    logic       SW_CHG;

    modport master (
        output BTN_SOUTH, BTN_WEST, BTN_EAST, SW,
        input  BTN_LVL, BTN_PRESS, BTN_REL, BTN_STEP, SW_LVL, SW_CHG
    );

    modport slave (
        input  BTN_SOUTH, BTN_WEST, BTN_EAST, SW,
        output BTN_LVL, BTN_PRESS, BTN_REL, BTN_STEP, SW_LVL, SW_CHG
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces 3 buttons and 4 switches; buttons get edge
// pulses and a press/auto-repeat step pulse.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000
) (
    input  logic               CLOCK,
    input  logic               RESET,
    btn_conditioner_if.slave   io
);
    localparam int unsigned NIN   = 7;
    localparam int unsigned NBTN  = 3;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W = $clog2(T_MAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    logic [NIN-1:0]  raw;
    logic [NIN-1:0]  sync1_q, sync2_q;
    logic [NIN-1:0]  deb_q, deb_d;
    logic [NIN-1:0]  tgl;
    logic [DB_W-1:0] cnt_q [NIN];
    logic [DB_W-1:0] cnt_d [NIN];

    logic [NBTN-1:0] rise, fall;
    logic [NBTN-1:0] press_q, rel_q, step_q, step_d;
    logic            chg_q;

    rpt_state_e       state_q [NBTN];
    rpt_state_e       state_d [NBTN];
    logic [TMR_W-1:0] timer_q [NBTN];
    logic [TMR_W-1:0] timer_d [NBTN];

    assign raw = {io.SW, io.BTN_EAST, io.BTN_WEST, io.BTN_SOUTH};

    always_comb begin
        for (int unsigned i = 0; i < NIN; i++) begin
            tgl[i]   = 1'b0;
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    tgl[i]   = 1'b1;
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise = tgl[NBTN-1:0] & ~deb_q[NBTN-1:0];
    assign fall = tgl[NBTN-1:0] &  deb_q[NBTN-1:0];

    // Repeat FSM reacts to the same-cycle debounce toggle so STEP lines up with PRESS.
    always_comb begin
        for (int unsigned b = 0; b < NBTN; b++) begin
            state_d[b] = state_q[b];
            timer_d[b] = timer_q[b];
            step_d[b]  = 1'b0;
            case (state_q[b])
                IDLE: begin
                    if (rise[b]) begin
                        step_d[b]  = 1'b1;
                        timer_d[b] = '0;
                        state_d[b] = DELAY;
                    end
                end
                DELAY: begin
                    if (fall[b]) begin
                        timer_d[b] = '0;
                        state_d[b] = IDLE;
                    end else if (timer_q[b] == TMR_W'(REPEAT_DELAY - 1)) begin
                        step_d[b]  = 1'b1;
                        timer_d[b] = '0;
                        state_d[b] = REPEAT;
                    end else begin
                        timer_d[b] = timer_q[b] + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall[b]) begin
                        timer_d[b] = '0;
                        state_d[b] = IDLE;
                    end else if (timer_q[b] == TMR_W'(REPEAT_PERIOD - 1)) begin
                        step_d[b]  = 1'b1;
                        timer_d[b] = '0;
                    end else begin
                        timer_d[b] = timer_q[b] + TMR_W'(1);
                    end
                end
                default: begin
                    timer_d[b] = '0;
                    state_d[b] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            step_q  <= '0;
            chg_q   <= 1'b0;
            for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= '0;
            for (int unsigned b = 0; b < NBTN; b++) begin
                state_q[b] <= IDLE;
                timer_q[b] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= rise;
            rel_q   <= fall;
            step_q  <= step_d;
            chg_q   <= |tgl[NIN-1:NBTN];
            for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
            for (int unsigned b = 0; b < NBTN; b++) begin
                state_q[b] <= state_d[b];
                timer_q[b] <= timer_d[b];
            end
        end
    end

    assign io.BTN_LVL   = deb_q[NBTN-1:0];
    assign io.SW_LVL    = deb_q[NIN-1:NBTN];
    assign io.BTN_PRESS = press_q;
    assign io.BTN_REL   = rel_q;
    assign io.BTN_STEP  = step_q;
    assign io.SW_CHG    = chg_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: history-window model checked every cycle plus
// directed scenarios with hand-computed expectations (N=4, D=10, P=5).
module tb_btn_conditioner;
    localparam int N    = 4;
    localparam int D    = 10;
    localparam int P    = 5;
    localparam int MAXC = 4096;

    logic CLOCK = 1'b0;
    logic RESET;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .REPEAT_DELAY    (D),
        .REPEAT_PERIOD   (P)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .io    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a level flips once its last N synchronized samples all disagree
    // with it and at least N edges passed since its last flip or reset.
    bit         hist [7][MAXC];
    bit   [6:0] mdeb;
    int         mark [7];
    int         pe   [3];
    bit   [2:0] held;

    always @(posedge CLOCK) begin
        logic [6:0] r;
        logic [6:0] tg;
        logic [2:0] ex_press, ex_rel, ex_step;
        logic       ex_chg;
        cyc++;
        r        = {bus.SW, bus.BTN_EAST, bus.BTN_WEST, bus.BTN_SOUTH};
        tg       = '0;
        ex_press = '0;
        ex_rel   = '0;
        ex_step  = '0;
        ex_chg   = 1'b0;
        if (cyc < MAXC) begin
            if (RESET) begin
                for (int i = 0; i < 7; i++) begin
                    hist[i][cyc] = 1'b0;
                    hist[i][cyc-1] = 1'b0;
                    mdeb[i] = 1'b0;
                    mark[i] = cyc;
                end
                held = '0;
            end else begin
                for (int i = 0; i < 7; i++) begin
                    hist[i][cyc] = r[i];
                    if (cyc >= mark[i] + N) begin
                        tg[i] = 1'b1;
                        for (int k = 2; k <= N + 1; k++)
                            if (hist[i][cyc-k] == mdeb[i]) tg[i] = 1'b0;
                    end
                    if (tg[i]) begin
                        mdeb[i] = ~mdeb[i];
                        mark[i] = cyc;
                    end
                end
                for (int b = 0; b < 3; b++) begin
                    ex_press[b] = tg[b] & mdeb[b];
                    ex_rel[b]   = tg[b] & ~mdeb[b];
                    if (ex_press[b]) begin
                        pe[b]      = cyc;
                        held[b]    = 1'b1;
                        ex_step[b] = 1'b1;
                    end else if (ex_rel[b]) begin
                        held[b] = 1'b0;
                    end else if (held[b] && (cyc - pe[b] >= D) && ((cyc - pe[b] - D) % P == 0)) begin
                        ex_step[b] = 1'b1;
                    end
                end
                ex_chg = |tg[6:3];
            end
        end
        #1;
        check("BTN_LVL",   7'(bus.BTN_LVL),   7'(mdeb[2:0]));
        check("SW_LVL",    7'(bus.SW_LVL),    7'(mdeb[6:3]));
        check("BTN_PRESS", 7'(bus.BTN_PRESS), 7'(ex_press));
        check("BTN_REL",   7'(bus.BTN_REL),   7'(ex_rel));
        check("BTN_STEP",  7'(bus.BTN_STEP),  7'(ex_step));
        check("SW_CHG",    7'(bus.SW_CHG),    7'(ex_chg));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    initial begin
        int         t;
        int         n_rel, n_step, n_chg;
        logic [2:0] acc;
        logic       seq [6];
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        RESET         = 1'b1;
        bus.BTN_SOUTH = 1'b0;
        bus.BTN_WEST  = 1'b0;
        bus.BTN_EAST  = 1'b0;
        bus.SW        = 4'b0000;
        tick(2);
        check("rst_btn_lvl", 7'(bus.BTN_LVL), 7'd0);
        check("rst_sw_lvl",  7'(bus.SW_LVL),  7'd0);
        check("rst_step",    7'(bus.BTN_STEP), 7'd0);
        RESET = 1'b0;
        tick(10);

        // EAST bounces shorter than N
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            bus.BTN_EAST = seq[i];
            tick(1);
            acc = acc | bus.BTN_LVL | bus.BTN_PRESS | bus.BTN_REL | bus.BTN_STEP;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1);
            acc = acc | bus.BTN_LVL | bus.BTN_PRESS | bus.BTN_REL | bus.BTN_STEP;
        end
        check("bounce_quiet", 7'(acc), 7'd0);
        tick(10);

        // EAST held 40 cycles
        t = cyc;
        bus.BTN_EAST = 1'b1;
        tick(5);
        check("east_lvl_t5", 7'(bus.BTN_LVL[2]), 7'd0);
        tick(1);
        check("east_lvl_t6",   7'(bus.BTN_LVL[2]),   7'd1);
        check("east_press_t6", 7'(bus.BTN_PRESS[2]), 7'd1);
        check("east_step_t6",  7'(bus.BTN_STEP[2]),  7'd1);
        tick(9);
        check("east_step_t15", 7'(bus.BTN_STEP[2]), 7'd0);
        tick(1);
        check("east_step_t16", 7'(bus.BTN_STEP[2]), 7'd1);
        for (int s = 21; s <= 36; s += 5) begin
            tick(5);
            check("east_step_rep", 7'(bus.BTN_STEP[2]), 7'd1);
        end
        tick(4);
        bus.BTN_EAST = 1'b0;
        n_rel = 0;
        n_step = 0;
        for (int i = 41; i <= 60; i++) begin
            tick(1);
            if (cyc - t == 46) check("east_rel_t46", 7'(bus.BTN_REL[2]), 7'd1);
            n_rel += int'(bus.BTN_REL[2]);
            if (cyc - t >= 42) n_step += int'(bus.BTN_STEP[2]);
        end
        check("east_rel_count",  7'(n_rel),  7'd1);
        check("east_step_after", 7'(n_step), 7'd0);
        tick(10);

        // switches: 0101 then SW3
        t = cyc;
        n_chg = 0;
        bus.SW = 4'b0101;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) bus.SW = 4'b1101;
            tick(1);
            n_chg += int'(bus.SW_CHG);
            if (i == 5)  check("sw_lvl_t5",  7'(bus.SW_LVL), 7'b0000000);
            if (i == 6)  check("sw_lvl_t6",  7'(bus.SW_LVL), 7'b0000101);
            if (i == 6)  check("sw_chg_t6",  7'(bus.SW_CHG), 7'd1);
            if (i == 16) check("sw_lvl_t16", 7'(bus.SW_LVL), 7'b0001101);
        end
        check("sw_chg_count", 7'(n_chg), 7'd2);
        bus.SW = 4'b0000;
        tick(12);

        // WEST interrupted by reset
        bus.BTN_WEST = 1'b1;
        tick(3);
        RESET = 1'b1;
        tick(1);
        check("rst_mid_lvl",   7'({bus.SW_LVL, bus.BTN_LVL}), 7'd0);
        check("rst_mid_pulse", 7'({bus.SW_CHG, bus.BTN_PRESS, bus.BTN_STEP}), 7'd0);
        RESET = 1'b0;
        tick(5);
        check("west_lvl_r5", 7'(bus.BTN_LVL[1]), 7'd0);
        tick(1);
        check("west_lvl_r6",   7'(bus.BTN_LVL[1]),   7'd1);
        check("west_press_r6", 7'(bus.BTN_PRESS[1]), 7'd1);
        bus.BTN_WEST = 1'b0;
        tick(20);

        // WEST and EAST together
        bus.BTN_WEST = 1'b1;
        bus.BTN_EAST = 1'b1;
        tick(6);
        check("dual_press", 7'(bus.BTN_PRESS), 7'b0000110);
        check("dual_step",  7'(bus.BTN_STEP),  7'b0000110);
        bus.BTN_WEST = 1'b0;
        bus.BTN_EAST = 1'b0;
        tick(20);

        // release landing on a repeat expiry (steps at t+6,16,21,26)
        t = cyc;
        bus.BTN_EAST = 1'b1;
        tick(20);
        bus.BTN_EAST = 1'b0;
        tick(6);
        check("rel_win_rel",  7'(bus.BTN_REL[2]),  7'd1);
        check("rel_win_step", 7'(bus.BTN_STEP[2]), 7'd0);
        check("rel_win_lvl",  7'(bus.BTN_LVL[2]),  7'd0);
        n_step = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_step += int'(bus.BTN_STEP[2]);
        end
        check("rel_win_idle", 7'(n_step), 7'd0);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
